// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolution stage: funct3 encodings,
// FSM state type and the branch-condition evaluator.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RES  = 2'd2,
    DONE = 2'd3
  } br_state_t;

  typedef struct packed {
    logic illegal;
    logic taken;
  } br_cond_t;

  // Unlisted encodings (010, 011) are illegal and never taken.
  function automatic br_cond_t branch_cond(input logic [2:0] f3,
                                           input logic       eq,
                                           input logic       lt,
                                           input logic       ltu);
    br_cond_t r;
    r.illegal = 1'b0;
    r.taken   = 1'b0;
    case (f3)
      F3_BEQ:  r.taken = eq;
      F3_BNE:  r.taken = ~eq;
      F3_BLT:  r.taken = lt;
      F3_BGE:  r.taken = ~lt;
      F3_BLTU: r.taken = ltu;
      F3_BGEU: r.taken = ~ltu;
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle between the multicycle control unit and the branch
// resolution stage.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  // Handshake: start is sampled only while busy=0 and captures all request
  // fields on that edge; done is a one-cycle pulse marking the result fields
  // valid, and those fields then hold until the next result is produced.
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] imm;
  logic            busy;
  logic            done;
  logic            taken;
  logic [XLEN-1:0] pc_next;
  logic            illegal;
  logic            misalign;

  modport master (
    output start, funct3, rd1, rd2, pc_cur, imm,
    input  busy, done, taken, pc_next, illegal, misalign
  );

  modport slave (
    input  start, funct3, rd1, rd2, pc_cur, imm,
    output busy, done, taken, pc_next, illegal, misalign
  );

endinterface

// File: rtl/branch_cmp.sv
// Combinational operand comparator: equality, signed less-than and unsigned
// less-than of two XLEN-wide operands.
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

endmodule

// File: rtl/branch_resolve_unit.sv
// Multicycle branch resolution: capture operands, register compare flags,
// resolve the condition and next PC, then pulse done.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_unit_if.slave  br,
  output br_state_t             state_dbg
);

  br_state_t       state;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic            eq_q;
  logic            lt_q;
  logic            ltu_q;
  logic            done_q;
  logic            taken_q;
  logic            illegal_q;
  logic            misalign_q;
  logic [XLEN-1:0] pc_next_q;

  logic            eq_c;
  logic            lt_c;
  logic            ltu_c;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .a   (a_q),
    .b   (b_q),
    .eq  (eq_c),
    .lt  (lt_c),
    .ltu (ltu_c)
  );

  // Resolution datapath; both adders wrap modulo 2^XLEN.
  br_cond_t        cond_c;
  logic [XLEN-1:0] pc_tgt_c;
  logic [XLEN-1:0] pc_seq_c;
  logic [XLEN-1:0] pc_sel_c;
  logic            misalign_c;

  always_comb begin
    cond_c     = branch_cond(f3_q, eq_q, lt_q, ltu_q);
    pc_tgt_c   = pc_q + imm_q;
    pc_seq_c   = pc_q + XLEN'(PC_STEP);
    pc_sel_c   = cond_c.taken ? pc_tgt_c : pc_seq_c;
    misalign_c = cond_c.taken && (pc_sel_c[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      f3_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      ltu_q      <= 1'b0;
      done_q     <= 1'b0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      pc_next_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (br.start) begin
            f3_q  <= br.funct3;
            a_q   <= br.rd1;
            b_q   <= br.rd2;
            pc_q  <= br.pc_cur;
            imm_q <= br.imm;
            state <= CMP;
          end
        end
        CMP: begin
          eq_q  <= eq_c;
          lt_q  <= lt_c;
          ltu_q <= ltu_c;
          state <= RES;
        end
        RES: begin
          taken_q    <= cond_c.taken;
          illegal_q  <= cond_c.illegal;
          misalign_q <= misalign_c;
          pc_next_q  <= pc_sel_c;
          done_q     <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign br.busy     = (state != IDLE);
  assign br.done     = done_q;
  assign br.taken    = taken_q;
  assign br.illegal  = illegal_q;
  assign br.misalign = misalign_q;
  assign br.pc_next  = pc_next_q;
  assign state_dbg   = state;

endmodule
